bus_write_master: RTL
=====================

# bus_write_master

Queued bus-write master that drives the shared 8-bit peripheral bus (BUS_ADDR/BUS_DATA/BUS_WE) feeding the memory-mapped output peripherals, including the LED register at 0xC0. Producers (the mouse-status path and the control logic) push (address, data) write requests into a small FIFO. The block arbitrates for the bus and replays each request as a timed write. It parks the address bus on an unmapped idle address between writes, because downstream peripherals latch on address match alone.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- HOLD_CYCLES, 1: cycles each write is held on the bus; 1..15.
- IDLE_ADDR, 8'hFF: parked bus address; no peripheral maps here.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  producer has a write request.
- REQ_ADDR  in  8  target peripheral address.
- REQ_DATA  in  8  data to write.
- REQ_READY  out  1  FIFO can accept; push occurs on edge with REQ_VALID && REQ_READY.
- BUS_GRANT  in  1  arbiter grants bus to this master.
- BUS_REQ  out  1  master requests the bus.
- BUS_ADDR  out  8  bus address (registered).
- BUS_DATA  out  8  bus data (registered).
- BUS_WE  out  1  write strobe (registered).
- DROP  out  1  one-cycle pulse: popped entry discarded (address == IDLE_ADDR).

## Operation
- FIFO: DEPTH entries of {addr, data}; read/write pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
- REQ_READY = !RESET && (count < DEPTH), from registered count. A push arriving while full is not accepted, even if a pop occurs on the same edge.
- Simultaneous push and pop: count unchanged, both pointers advance.
- BUS_REQ = (count != 0) || (state != IDLE).
- FSM states:
  - IDLE: bus parked. If count != 0 and BUS_GRANT, pop the head on this edge. If head addr == IDLE_ADDR, pulse DROP and stay IDLE. Otherwise load BUS_ADDR/BUS_DATA from the head, set BUS_WE = 1, load hold counter = HOLD_CYCLES-1, and go to WRITE.
  - WRITE: outputs held. When hold counter == 0, go to GAP and park the bus (BUS_ADDR = IDLE_ADDR, BUS_DATA = 0, BUS_WE = 0). Otherwise decrement.
  - GAP: exactly one parked cycle, then IDLE.
- BUS_GRANT is sampled only in IDLE. Deasserting it during WRITE/GAP does not abort the write in progress.
- FIFO ordering strictly preserved; no coalescing of writes to the same address.

## Timing
- Reset values: BUS_ADDR = IDLE_ADDR, BUS_DATA = 8'h00, BUS_WE = 0, BUS_REQ = 0, DROP = 0, REQ_READY = 0 while RESET is high. Count = 0, pointers = 0, state IDLE.
- Reset mid-operation (any state): all of the above take effect on the next edge. Queued entries are lost. No partial write is extended.
- Latency: a request pushed at edge k into an empty FIFO with BUS_GRANT high appears on the bus after edge k+1.
- Each write occupies HOLD_CYCLES bus cycles, followed by 1 GAP cycle. The first-attempt IDLE cycle is needed for the pop decision.
- Sustained throughput with grant held: one write per HOLD_CYCLES+2 cycles.
- Dropped entry: consumes one IDLE cycle and produces a DROP pulse. BUS_WE stays 0 and BUS_ADDR stays IDLE_ADDR.
- With BUS_GRANT low, the FIFO fills. REQ_READY falls after the edge on which count reaches DEPTH.

## Test plan
- Reset: hold RESET 3 cycles with REQ_VALID = 1 -> BUS_ADDR = FF, BUS_WE = 0, BUS_REQ = 0, REQ_READY = 0. No push occurs; count = 0 after release.
- Single write, HOLD_CYCLES = 1, grant high: push (C0, 5A) at edge k -> after edge k+1 BUS_ADDR = C0, BUS_DATA = 5A, BUS_WE = 1 for 1 cycle. Then FF/00/0 for 1 cycle. An attached LED register reads 5A.
- Back-pressure: grant low, push 5 requests (C0, 01..05), DEPTH = 4 -> first 4 accepted, REQ_READY = 0, 5th held. Raise grant -> bus shows 01, 02, 03, 04, 05 in order, spaced 3 cycles apart.
- Grant removal: grant drops in the first WRITE cycle with HOLD_CYCLES = 3 -> write completes 3 cycles. Next entry waits in IDLE until grant returns.
- Drop: push (FF, AA) then (C0, 11) -> DROP pulses once, BUS_WE never asserts for AA, then the C0/11 write appears.
- Reset mid-write: assert RESET during the second WRITE cycle with 2 entries queued -> next edge parks the bus, count = 0, and no further writes occur after release.

Source files
------------

// File: rtl/bus_write_master.sv
// Queued bus-write master: buffers (addr, data) requests in a FIFO and replays
// each one as a timed write on the shared peripheral bus, parking it between writes.
module bus_write_master #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 1,
  parameter logic [7:0]  IDLE_ADDR   = 8'hFF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_VALID,
  input  logic [7:0] REQ_ADDR,
  input  logic [7:0] REQ_DATA,
  output logic       REQ_READY,
  input  logic       BUS_GRANT,
  output logic       BUS_REQ,
  output logic [7:0] BUS_ADDR,
  output logic [7:0] BUS_DATA,
  output logic       BUS_WE,
  output logic       DROP
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned HW = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_GAP
  } state_t;

  logic [7:0]    r_mem_addr [DEPTH];
  logic [7:0]    r_mem_data [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [HW-1:0] r_hold;
  logic [HW-1:0] w_hold_nxt;
  logic [7:0]    r_bus_addr;
  logic [7:0]    w_bus_addr_nxt;
  logic [7:0]    r_bus_data;
  logic [7:0]    w_bus_data_nxt;
  logic          r_bus_we;
  logic          w_bus_we_nxt;
  logic          r_drop;
  logic          w_drop_nxt;

  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_head_addr;
  logic [7:0]    w_head_data;

  // Ready and bus request derive from registered state; both forced low in reset.
  assign REQ_READY   = !RESET && (r_count < CW'(DEPTH));
  assign BUS_REQ     = !RESET && ((r_count != '0) || (r_state != S_IDLE));
  assign w_push      = REQ_VALID && REQ_READY;
  assign w_head_addr = r_mem_addr[r_rd_ptr];
  assign w_head_data = r_mem_data[r_rd_ptr];

  assign BUS_ADDR = r_bus_addr;
  assign BUS_DATA = r_bus_data;
  assign BUS_WE   = r_bus_we;
  assign DROP     = r_drop;

  // FIFO storage
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= REQ_ADDR;
      r_mem_data[r_wr_ptr] <= REQ_DATA;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // State and registered bus outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_hold     <= '0;
      r_bus_addr <= IDLE_ADDR;
      r_bus_data <= 8'h00;
      r_bus_we   <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold     <= w_hold_nxt;
      r_bus_addr <= w_bus_addr_nxt;
      r_bus_data <= w_bus_data_nxt;
      r_bus_we   <= w_bus_we_nxt;
      r_drop     <= w_drop_nxt;
    end
  end

  // Next-state: grant is only looked at in IDLE, so a started write always completes
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_nxt     = r_hold;
    w_bus_addr_nxt = r_bus_addr;
    w_bus_data_nxt = r_bus_data;
    w_bus_we_nxt   = r_bus_we;
    w_drop_nxt     = 1'b0;
    w_pop          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_count != '0) && BUS_GRANT) begin
          w_pop = 1'b1;
          if (w_head_addr == IDLE_ADDR) begin
            w_drop_nxt = 1'b1;
          end else begin
            w_bus_addr_nxt = w_head_addr;
            w_bus_data_nxt = w_head_data;
            w_bus_we_nxt   = 1'b1;
            w_hold_nxt     = HW'(HOLD_CYCLES - 1);
            w_state_nxt    = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (r_hold == '0) begin
          w_bus_addr_nxt = IDLE_ADDR;
          w_bus_data_nxt = 8'h00;
          w_bus_we_nxt   = 1'b0;
          w_state_nxt    = S_GAP;
        end else begin
          w_hold_nxt = r_hold - HW'(1);
        end
      end
      S_GAP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_bus_addr_nxt = IDLE_ADDR;
        w_bus_data_nxt = 8'h00;
        w_bus_we_nxt   = 1'b0;
        w_state_nxt    = S_IDLE;
      end
    endcase
  end

endmodule
